pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 107, payload width in bits (alu_result 32 + dm_rd 32 + pc8 32 + dst 5 + rfwr 1 + m2sel 2 + dmrdop 3).
REQ-002 SHALL have parameter CLR_ON_FLUSH, default 0; when 1, a flush also zeroes the stored payload.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous kill of all held entries.
REQ-006 SHALL have port in_valid  input  1  upstream entry present.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port in_ready  output  1  stage accepts an entry this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-010 SHALL have port out_data  output  DATA_W  oldest held payload.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the entry this cycle.
REQ-012 SHALL have port occ  output  2  number of held entries (0..2).

Function
REQ-013 SHALL transfer in on (in_valid & in_ready) and out on (out_valid & out_ready), both at the clk rising edge.
REQ-014 SHALL implement FSM EMPTY/ONE/TWO holding a main register (drives out_data) and a skid register.
REQ-015 EMPTY: in_valid -> ONE with main <= in_data; otherwise stay EMPTY.
REQ-016 ONE: in only -> TWO with skid <= in_data; out only -> EMPTY; in and out -> stay ONE with main <= in_data; neither -> stay ONE.
REQ-017 TWO: out_ready -> ONE with main <= skid; otherwise stay TWO; no input is accepted in TWO.
REQ-018 SHALL drive in_ready = (state != TWO) directly from the state register, with no combinational path from out_ready.
REQ-019 SHALL drive out_valid = (state != EMPTY) and occ = 0/1/2 for EMPTY/ONE/TWO.
REQ-020 SHALL have latency 1 cycle from accepted input to out_valid when EMPTY, and sustain 1 transfer/cycle when out_ready is held high.
REQ-021 SHALL preserve entry order: no loss, duplication or reordering.
REQ-022 SHALL give flush priority over all transfers: next state EMPTY, any same-cycle input is dropped, and payload registers are zeroed only when CLR_ON_FLUSH = 1.
REQ-023 SHALL hold out_data stable while out_valid = 1 and out_ready = 0.

Reset
REQ-024 SHALL, when reset is asserted, immediately set state EMPTY, main and skid to 0, out_valid 0, occ 0, in_ready 1.
REQ-025 SHALL ignore all inputs while reset is high; the first transfer is possible on the first rising edge after deassertion.
REQ-026 SHALL return to the REQ-024 values when reset is asserted mid-operation, including in state TWO, and SHALL not emit pending entries.

Configuration
REQ-027 SHALL, with macro PIPE_SKID_BUFFER_EN defined, implement REQ-014..REQ-018 as written.
REQ-028 SHALL, without PIPE_SKID_BUFFER_EN, omit the skid register and use states EMPTY/ONE only:
- in_ready = (state == EMPTY) | out_ready (combinational);
- occ is never 2;
- all other requirements still apply.

Verification
REQ-029 Reset then in_valid = 1, in_data = 0x1234, out_ready = 1 -> next cycle out_valid = 1, out_data = 0x1234, occ = 1.
REQ-030 out_ready = 0, send A = 0x1 then B = 0x2 -> occ = 2, in_ready = 0, out_data = 0x1; then out_ready = 1 -> outputs 0x1 then 0x2 on consecutive cycles.
REQ-031 out_ready = 1, 100-entry incrementing stream -> 100 outputs in order, one per cycle, in_ready never 0 (both configurations).
REQ-032 occ = 2 with flush = 1 and in_valid = 1 in the same cycle -> next cycle occ = 0, out_valid = 0, input dropped; with CLR_ON_FLUSH = 1 also out_data = 0.
REQ-033 Reset asserted asynchronously mid-cycle in TWO -> out_valid = 0 and out_data = 0 before the next clk edge.
REQ-034 Without PIPE_SKID_BUFFER_EN: ONE with out_ready = 0 -> in_ready = 0; toggling out_ready = 1 in the same cycle -> in_ready = 1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register; define PIPE_SKID_BUFFER_EN for a 2-entry skid buffer with registered in_ready
module pipe_stage_reg #(
  parameter int DATA_W       = 107,
  parameter bit CLR_ON_FLUSH = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occ
);
`ifdef PIPE_SKID_BUFFER_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
`else
  typedef enum logic [1:0] {EMPTY, ONE} state_t;
`endif
  state_t state, state_nx;
  logic [DATA_W-1:0] main_q, main_nx;
  assign out_data  = main_q;
  assign out_valid = state != EMPTY;
  assign occ       = state;
`ifdef PIPE_SKID_BUFFER_EN
  logic [DATA_W-1:0] skid_q, skid_nx;
  assign in_ready = state != TWO;
  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    if (flush) begin
      state_nx = EMPTY;
      if (CLR_ON_FLUSH) begin
        main_nx = '0;
        skid_nx = '0;
      end
    end else begin
      case (state)
        EMPTY: if (in_valid) begin
          state_nx = ONE;
          main_nx  = in_data;
        end
        ONE: if (in_valid && out_ready) main_nx = in_data;
          else if (in_valid) begin
            state_nx = TWO;
            skid_nx  = in_data;
          end else if (out_ready) state_nx = EMPTY;
        TWO: if (out_ready) begin
          state_nx = ONE;
          main_nx  = skid_q;
        end
        default: state_nx = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) skid_q <= '0;
    else skid_q <= skid_nx;
`else
  assign in_ready = state == EMPTY || out_ready;
  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    if (flush) begin
      state_nx = EMPTY;
      if (CLR_ON_FLUSH) main_nx = '0;
    end else if (in_valid && in_ready) begin
      state_nx = ONE;
      main_nx  = in_data;
    end else if (out_ready) state_nx = EMPTY;
  end
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
    end else begin
      state  <= state_nx;
      main_q <= main_nx;
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of pipe_stage_reg (CLR_ON_FLUSH=1), either PIPE_SKID_BUFFER_EN setting
module tb_pipe_stage_reg;
  localparam int W = 107;
`ifdef PIPE_SKID_BUFFER_EN
  localparam logic [1:0] FULL = 2'd2;
`else
  localparam logic [1:0] FULL = 2'd1;
`endif
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [W-1:0] in_data = '0, out_data;
  logic [1:0] occ;
  int errors = 0, checks = 0;

  pipe_stage_reg #(.DATA_W(W), .CLR_ON_FLUSH(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic status(input string tag, input logic v, input logic [1:0] o, input logic [W-1:0] d);
    check({tag, ".valid"}, out_valid, v);
    check({tag, ".occ"}, occ, o);
    if (v) check({tag, ".data"}, out_data, d);
  endtask

  initial begin
    #2;
    check("rst.ready", in_ready, 1'b1);
    status("rst", 1'b0, 2'd0, '0);
    check("rst.data", out_data, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 'h1234, 1'b1);
    @(negedge clk);
    status("first", 1'b1, 2'd1, 'h1234);
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    status("drain", 1'b0, 2'd0, '0);
    drive(1'b1, 'h1, 1'b0);
    @(negedge clk);
    status("a", 1'b1, 2'd1, 'h1);
    drive(1'b1, 'h2, 1'b0);
`ifdef PIPE_SKID_BUFFER_EN
    @(negedge clk);
    status("ab", 1'b1, 2'd2, 'h1);
    check("ab.ready", in_ready, 1'b0);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    status("hold", 1'b1, 2'd2, 'h1);
    out_ready = 1'b1;
    @(negedge clk);
    status("pop_b", 1'b1, 2'd1, 'h2);
`else
    #1 check("stall.ready", in_ready, 1'b0);
    @(negedge clk);
    status("hold", 1'b1, 2'd1, 'h1);
    out_ready = 1'b1;
    #1 check("toggle.ready", in_ready, 1'b1);
    @(negedge clk);
    status("pop_b", 1'b1, 2'd1, 'h2);
    drive(1'b0, '0, 1'b1);
`endif
    @(negedge clk);
    status("empty", 1'b0, 2'd0, '0);
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, W'(i + 'h100), 1'b1);
      #1 check("stream.ready", in_ready, 1'b1);
      @(negedge clk);
      status("stream", 1'b1, 2'd1, W'(i + 'h100));
    end
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    status("stream_end", 1'b0, 2'd0, '0);
    drive(1'b1, 'hA, 1'b0);
    @(negedge clk);
`ifdef PIPE_SKID_BUFFER_EN
    drive(1'b1, 'hB, 1'b0);
    @(negedge clk);
`endif
    status("fill", 1'b1, FULL, 'hA);
    flush = 1'b1;
    drive(1'b1, 'hC, 1'b1);
    @(negedge clk);
    status("flush", 1'b0, 2'd0, '0);
    check("flush.data", out_data, 0);
    flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    status("flush_drop", 1'b0, 2'd0, '0);
    drive(1'b1, 'h11, 1'b0);
    @(negedge clk);
`ifdef PIPE_SKID_BUFFER_EN
    drive(1'b1, 'h22, 1'b0);
    @(negedge clk);
`endif
    status("pre_rst", 1'b1, FULL, 'h11);
    drive(1'b1, 'h33, 1'b1);
    #2 reset = 1'b1;
    #1;
    status("async_rst", 1'b0, 2'd0, '0);
    check("async_rst.data", out_data, 0);
    check("async_rst.ready", in_ready, 1'b1);
    @(negedge clk);
    status("rst_ignore", 1'b0, 2'd0, '0);
    reset = 1'b0;
    drive(1'b1, 'h55, 1'b0);
    @(negedge clk);
    status("post_rst", 1'b1, 2'd1, 'h55);
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    status("final", 1'b0, 2'd0, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
